// File: rtl/gfx_font_pkg.sv
// Shared font/glyph constants, shifter state encoding and ROM address builder.
// GLYPH_SHIFTER_ATTR_EN widens the pixel output to a 4-bit colour index.
package gfx_font_pkg;

    localparam int GLYPH_W      = 8;
    localparam int GLYPH_ROWS   = 16;
    localparam int FONT_ADDR_W  = 12;
    localparam int FONT_ROM_LAT = 2;

    localparam int ROW_W  = $clog2(GLYPH_ROWS);
    localparam int CODE_W = FONT_ADDR_W - ROW_W;
    localparam int CNT_W  = $clog2(GLYPH_W);
    localparam int ATTR_W = 8;

`ifdef GLYPH_SHIFTER_ATTR_EN
    localparam int PIX_W = 4;
`else
    localparam int PIX_W = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    function automatic logic [FONT_ADDR_W-1:0] font_addr(
        input logic [CODE_W-1:0] code,
        input logic [ROW_W-1:0]  row
    );
        return {code, row};
    endfunction

endpackage

// File: rtl/glyph_shifter_if.sv
// Character offer handshake into the glyph shifter (code, row, optional attribute, flush).
// char_attr exists only when GLYPH_SHIFTER_ATTR_EN is defined.
interface glyph_shifter_if;
    import gfx_font_pkg::*;

    logic              char_valid;
    logic              char_ready;
    logic [CODE_W-1:0] char_code;
    logic [ROW_W-1:0]  char_row;
    logic              flush;
`ifdef GLYPH_SHIFTER_ATTR_EN
    logic [ATTR_W-1:0] char_attr;

    modport master (
        output char_valid, char_code, char_row, char_attr, flush,
        input  char_ready
    );
    modport slave (
        input  char_valid, char_code, char_row, char_attr, flush,
        output char_ready
    );
`else
    modport master (
        output char_valid, char_code, char_row, flush,
        input  char_ready
    );
    modport slave (
        input  char_valid, char_code, char_row, flush,
        output char_ready
    );
`endif

endinterface

// File: rtl/glyph_shifter.sv
// Text-mode pixel serializer: fetches a glyph row from the 2-cycle font ROM and shifts it out MSB-first.
// Optional GLYPH_SHIFTER_ATTR_EN turns each pixel into a 4-bit fg/bg colour index.
module glyph_shifter
    import gfx_font_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    glyph_shifter_if.slave         char_bus,
    output logic                   rom_enable,
    output logic                   rom_next,
    output logic [FONT_ADDR_W-1:0] rom_addr,
    input  logic [GLYPH_W-1:0]     rom_data,
    output logic                   pix_valid,
    output logic [PIX_W-1:0]       pix,
    output logic                   underrun
);

    // Offering at this count lands the fetched row exactly on the last pixel.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(GLYPH_W - 1);
    localparam logic [CNT_W-1:0] CNT_OFFER = CNT_W'(GLYPH_W - 1 - FONT_ROM_LAT);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    underrun_nxt;
    logic                    ready;
    logic                    accept;
    logic                    load;
    logic [FONT_ROM_LAT:1]   vld_p;
    logic [GLYPH_W-1:0]      shift;
    logic [GLYPH_W-1:0]      shift_nxt;
    logic [PIX_W-1:0]        pix_nxt;
`ifdef GLYPH_SHIFTER_ATTR_EN
    logic [ATTR_W-1:0]       attr_p1;
    logic [ATTR_W-1:0]       attr_cur;
    logic [ATTR_W-1:0]       attr_nxt;
`endif

    assign ready               = (state == IDLE) || (state == RUN && cnt == CNT_OFFER);
    assign char_bus.char_ready = ready;
    assign accept              = char_bus.char_valid & ready & ~char_bus.flush;
    assign rom_enable          = accept;
    assign rom_addr            = font_addr(char_bus.char_code, char_bus.char_row);
    assign load                = vld_p[FONT_ROM_LAT] & ~char_bus.flush;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        underrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = FILL;
            end
            FILL: begin
                if (load) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    if (load) begin
                        cnt_nxt = '0;
                    end else begin
                        state_nxt    = IDLE;
                        underrun_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort discards the outstanding fetch and suppresses the starvation pulse.
        if (char_bus.flush) begin
            state_nxt    = IDLE;
            underrun_nxt = 1'b0;
        end
    end

    always_comb begin
        shift_nxt = shift;
        if (load) begin
            shift_nxt = rom_data;
        end else if (state == RUN) begin
            shift_nxt = shift << 1;
        end
`ifdef GLYPH_SHIFTER_ATTR_EN
        attr_nxt = load ? attr_p1 : attr_cur;
        pix_nxt  = shift_nxt[GLYPH_W-1] ? attr_nxt[7:4] : attr_nxt[3:0];
`else
        pix_nxt  = shift_nxt[GLYPH_W-1];
`endif
        if (state_nxt != RUN) pix_nxt = '0;
    end

    // Stage boundary: control state, fetch-valid pipeline and registered pixel output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vld_p     <= '0;
            rom_next  <= 1'b0;
            pix_valid <= 1'b0;
            pix       <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vld_p     <= {vld_p[FONT_ROM_LAT-1:1] & {(FONT_ROM_LAT-1){~char_bus.flush}}, accept};
            rom_next  <= rom_enable;
            pix_valid <= (state_nxt == RUN);
            pix       <= pix_nxt;
            underrun  <= underrun_nxt;
        end
    end

    // Stage boundary: glyph shifter and attribute hold registers (data only).
    always_ff @(posedge clk) begin
        shift <= shift_nxt;
`ifdef GLYPH_SHIFTER_ATTR_EN
        if (accept) attr_p1 <= char_bus.char_attr;
        attr_cur <= attr_nxt;
`endif
    end

endmodule
